fft_reorder: RTL and testbench
==============================

# fft_reorder

Output reorder stage that sits directly downstream of `fft` in the one-segment receiver chain. It accepts the 64 complex FFT results per symbol in bit-reversed arrival order. It re-emits them in natural bin order (0..63) as one contiguous burst, with index and frame markers for the demapper. Two ping-pong banks let back-to-back symbols stream with no stall and no dropped sample.

## Interface
- `N_LOG2`, default 6: log2 of points per symbol (64).
- `DW`, default 11: width of each real/imag sample; two's complement, passed through unmodified.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  input sample strobe from `fft`.
- `sop_i`  in  1  first sample of a symbol; qualified by `valid_i`.
- `xr`  in  DW  real part of the input sample.
- `xi`  in  DW  imag part of the input sample.
- `valid_o`  out  1  output sample valid.
- `yr`  out  DW  real part, natural order.
- `yi`  out  DW  imag part, natural order.
- `idx_o`  out  N_LOG2  bin index of the current output.
- `sop_o`  out  1  high with `idx_o`=0.
- `eop_o`  out  1  high with `idx_o`=63.

## Operation
- Storage: 2 banks × 64 entries × 2·DW. Memory contents are not reset.
- Per-bank `full` flag.
- Write side:
  - `wbank` (1 bit) and `wcnt` (N_LOG2 bits).
  - Each cycle with `valid_i`=1, write {`xr`,`xi`} to bank `wbank` at address bitrev(`wcnt`), then `wcnt`++.
  - bitrev reverses all N_LOG2 bits: 1→32, 2→16, 3→48, 63→63.
  - When `wcnt` wraps 63→0, set `full[wbank]` and toggle `wbank`.
  - `sop_i`=1 with `valid_i`=1: the sample is written at address 0 and `wcnt` becomes 1. Any partial frame in the current bank is discarded (overwritten); the bank is not marked full. `sop_i` when `wcnt`=0 behaves as a normal first sample.
  - `valid_i`=0: no write, counters hold. Gaps of any length are legal.
- Read side FSM:
  - States IDLE and DRAIN; registers `rbank` and `rcnt`.
  - IDLE→DRAIN when `full[rbank]`=1. In DRAIN, issue a read of bank `rbank` at address `rcnt` each cycle, then `rcnt`++.
  - When the read at `rcnt`=63 is issued: clear `full[rbank]` and toggle `rbank`.
    - If the new `rbank` is already full, stay in DRAIN with `rcnt`=0, giving a seamless next burst.
    - Otherwise go to IDLE.
  - Output register: `valid_o`, `yr`/`yi`, `idx_o`=`rcnt` of the issued read, `sop_o`=(`idx_o`==0), `eop_o`=(`idx_o`==63).
- Overflow cannot occur. A bank refills no earlier than 64 accepted samples after its read starts, and it is freed on the edge of its last read.
- Reset (`rst`=0, asynchronous):
  - `valid_o`, `sop_o`, `eop_o`=0; `yr`, `yi`, `idx_o`=0.
  - `wbank`=`rbank`=0, `wcnt`=`rcnt`=0, both `full`=0, FSM=IDLE.
  - Reset mid-frame or mid-drain abandons all data. The output burst stops immediately and never resumes for that data.

## Timing
- Let E0 be the clock edge sampling the 64th input sample.
  - `full` is set at E0.
  - First read is issued at E0+1.
  - `valid_o`/`sop_o` with `idx_o`=0 are visible after E0+2.
  - Burst of exactly 64 consecutive `valid_o` cycles; `eop_o` is visible after E0+65.
- Latency from last input to first output: 2 cycles. It is independent of input gaps.
- Continuous input (valid_i held high) gives continuous output: a 128-cycle burst for two symbols with no bubble between `eop_o` and the next `sop_o`.
- `valid_o` is never high for a non-contiguous burst; each burst is 64 cycles, or a multiple of 64 cycles when chained.
- Output data is registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `rst`=0 at time 1, release at 3 → all outputs 0; no `valid_o` through 200 cycles with `valid_i`=0.
- Single symbol with `xr`=arrival count c, `xi`=−c, continuous `valid_i`:
  - `valid_o` starts 2 cycles after the last input and lasts 64 cycles.
  - `idx_o`=0,1,2,3 → `yr`=0,32,16,48; `idx_o`=63 → 63; `yi`=−`yr`.
  - `sop_o` occurs only on the first output cycle, `eop_o` only on the last.
- Two symbols back-to-back (128 continuous `valid_i`) → 128 consecutive `valid_o` cycles. Second-burst data matches the second symbol, with `sop_o` at output cycle 64.
- `valid_i` every other cycle for one symbol → the output burst is still 64 contiguous cycles, starting 2 cycles after the 64th accepted sample.
- `sop_i` asserted on the 21st sample of a frame, followed by 63 more samples → one burst containing only the restarted frame; the first 20 samples never appear.
- Async reset asserted at `idx_o`=30 of a burst → `valid_o` falls without waiting for a clock; after release, no further output until a new full symbol arrives.

Source files
------------

// File: rtl/fft_reorder_if.sv
// Sample streams around the FFT reorder stage: bit-reversed samples in,
// natural-order samples out with bin index and frame markers.
interface fft_reorder_if #(
  parameter int N_LOG2 = 6,
  parameter int DW     = 11
);
  logic              valid_i;
  logic              sop_i;
  logic [DW-1:0]     xr;
  logic [DW-1:0]     xi;
  logic              valid_o;
  logic [DW-1:0]     yr;
  logic [DW-1:0]     yi;
  logic [N_LOG2-1:0] idx_o;
  logic              sop_o;
  logic              eop_o;

  modport master (
    output valid_i, sop_i, xr, xi,
    input  valid_o, yr, yi, idx_o, sop_o, eop_o
  );

  modport slave (
    input  valid_i, sop_i, xr, xi,
    output valid_o, yr, yi, idx_o, sop_o, eop_o
  );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: stores bit-reversed FFT output and replays it
// in natural bin order as one contiguous 64-sample burst per symbol.
module fft_reorder #(
  parameter int N_LOG2 = 6,
  parameter int DW     = 11
) (
  input logic          clk,
  input logic          rst,
  fft_reorder_if.slave bus
);

  localparam int DEPTH = 1 << N_LOG2;

  typedef enum logic {IDLE, DRAIN} state_e;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = a[N_LOG2-1-i];
    end
    return r;
  endfunction

  logic [2*DW-1:0]   mem [2][DEPTH];

  state_e            state_q, state_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [N_LOG2-1:0] wcnt_q, wcnt_d;
  logic [N_LOG2-1:0] rcnt_q, rcnt_d;
  logic [1:0]        full_q, full_d;

  logic              valid_q, valid_d;
  logic [DW-1:0]     yr_q, yr_d;
  logic [DW-1:0]     yi_q, yi_d;
  logic [N_LOG2-1:0] idx_q, idx_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;

  logic [N_LOG2-1:0] wr_addr;
  logic [2*DW-1:0]   rd_data;

  always_comb begin
    state_d = state_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    full_d  = full_q;
    valid_d = 1'b0;
    yr_d    = yr_q;
    yi_d    = yi_q;
    idx_d   = idx_q;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    wr_addr = bus.sop_i ? '0 : bitrev(wcnt_q);
    rd_data = mem[rbank_q][rcnt_q];

    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        valid_d      = 1'b1;
        {yr_d, yi_d} = rd_data;
        idx_d        = rcnt_q;
        sop_d        = (rcnt_q == '0);
        eop_d        = (rcnt_q == '1);
        rcnt_d       = rcnt_q + N_LOG2'(1);
        // Last read frees the bank; chain straight into the other bank if it is ready.
        if (rcnt_q == '1) begin
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
          if (!full_q[~rbank_q]) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A restart marker discards the partial frame without marking the bank full.
    if (bus.valid_i) begin
      if (bus.sop_i) begin
        wcnt_d = N_LOG2'(1);
      end else begin
        wcnt_d = wcnt_q + N_LOG2'(1);
        if (wcnt_q == '1) begin
          full_d[wbank_q] = 1'b1;
          wbank_d         = ~wbank_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.valid_i) begin
      mem[wbank_q][wr_addr] <= {bus.xr, bus.xi};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      full_q  <= '0;
      valid_q <= 1'b0;
      yr_q    <= '0;
      yi_q    <= '0;
      idx_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      yr_q    <= yr_d;
      yi_q    <= yi_d;
      idx_q   <= idx_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.yr      = yr_q;
  assign bus.yi      = yi_q;
  assign bus.idx_o   = idx_q;
  assign bus.sop_o   = sop_q;
  assign bus.eop_o   = eop_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder: stimulus pushes expected natural-order
// samples with their due cycle; a negedge monitor pops and compares them.
module tb_fft_reorder;

  localparam int N_LOG2 = 6;
  localparam int DW     = 11;
  localparam int MASK   = (1 << DW) - 1;

  typedef struct {
    int cyc;
    int yr;
    int yi;
    int idx;
    int sop;
    int eop;
  } exp_t;

  logic clk;
  logic rst;
  int   edgeCnt;
  int   checks;
  int   failures;
  int   lastEnd;
  exp_t sb[$];

  fft_reorder_if #(.N_LOG2(N_LOG2), .DW(DW)) bus ();

  fft_reorder #(.N_LOG2(N_LOG2), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edgeCnt = 0;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  function automatic int bitrev6(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      if (k[i]) r = r | (1 << (5 - i));
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  // Sample c of a frame carries xr = base+c, xi = -(base+c); bin k therefore holds base+bitrev(k).
  task automatic applyStimulus(input int base, input int count, input int gap,
                               input bit sopFirst, input bit expectBurst);
    int lastEdge;
    int start;
    int v;
    exp_t e;
    lastEdge = 0;
    for (int c = 0; c < count; c++) begin
      bus.valid_i = 1'b1;
      bus.sop_i   = sopFirst && (c == 0);
      bus.xr      = DW'(base + c);
      bus.xi      = DW'(-(base + c));
      @(posedge clk);
      #1;
      lastEdge    = edgeCnt;
      bus.valid_i = 1'b0;
      bus.sop_i   = 1'b0;
      if (c < count - 1) begin
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    if (expectBurst) begin
      start = lastEdge + 2;
      if (lastEnd + 1 > start) start = lastEnd + 1;
      for (int k = 0; k < 64; k++) begin
        v     = base + bitrev6(k);
        e.cyc = start + k;
        e.yr  = v & MASK;
        e.yi  = (-v) & MASK;
        e.idx = k;
        e.sop = (k == 0) ? 1 : 0;
        e.eop = (k == 63) ? 1 : 0;
        sb.push_back(e);
      end
      lastEnd = start + 63;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_complete", sb.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst && bus.valid_o) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid_o", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("burst_cycle", edgeCnt, e.cyc);
        checkOutput("yr", int'(bus.yr), e.yr);
        checkOutput("yi", int'(bus.yi), e.yi);
        checkOutput("idx_o", int'(bus.idx_o), e.idx);
        checkOutput("sop_o", int'(bus.sop_o), e.sop);
        checkOutput("eop_o", int'(bus.eop_o), e.eop);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    checks      = 0;
    failures    = 0;
    lastEnd     = -1000;
    bus.valid_i = 1'b0;
    bus.sop_i   = 1'b0;
    bus.xr      = '0;
    bus.xi      = '0;
    rst         = 1'b1;

    #1 rst = 1'b0;
    #1;
    checkOutput("reset_valid_o", int'(bus.valid_o), 0);
    checkOutput("reset_sop_o", int'(bus.sop_o), 0);
    checkOutput("reset_eop_o", int'(bus.eop_o), 0);
    checkOutput("reset_yr", int'(bus.yr), 0);
    checkOutput("reset_yi", int'(bus.yi), 0);
    checkOutput("reset_idx_o", int'(bus.idx_o), 0);
    #1 rst = 1'b1;

    $display("[TB] idle for 200 cycles");
    repeat (200) @(negedge clk);
    @(posedge clk);
    #1;

    $display("[TB] single symbol");
    applyStimulus(0, 64, 0, 1'b1, 1'b1);
    waitDrain();

    $display("[TB] two symbols back to back");
    @(posedge clk);
    #1;
    applyStimulus(100, 64, 0, 1'b1, 1'b1);
    applyStimulus(200, 64, 0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] gapped input");
    @(posedge clk);
    #1;
    applyStimulus(300, 64, 1, 1'b1, 1'b1);
    waitDrain();

    $display("[TB] restart on 21st sample");
    @(posedge clk);
    #1;
    applyStimulus(500, 20, 0, 1'b1, 1'b0);
    applyStimulus(600, 64, 0, 1'b1, 1'b1);
    waitDrain();

    $display("[TB] reset in the middle of a burst");
    @(posedge clk);
    #1;
    applyStimulus(700, 64, 0, 1'b1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.valid_o && bus.idx_o == N_LOG2'(30)) && n < 500);
    checkOutput("reached_idx30", (n < 500) ? 1 : 0, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_valid_o", int'(bus.valid_o), 0);
    checkOutput("async_reset_idx_o", int'(bus.idx_o), 0);
    checkOutput("async_reset_sop_o", int'(bus.sop_o), 0);
    checkOutput("async_reset_eop_o", int'(bus.eop_o), 0);
    sb.delete();
    lastEnd = -1000;
    #4 rst = 1'b1;
    repeat (100) @(negedge clk);
    @(posedge clk);
    #1;
    applyStimulus(800, 64, 0, 1'b1, 1'b1);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
